// File: rtl/cnn_pkg.sv
// Constants shared by simpleCNN and its window generator.
// The IMGIN byte layout is defined here.
package cnn_pkg;

  localparam int IMG_W   = 28;
  localparam int WIN     = 5;
  localparam int PIX_W   = 8;
  localparam int OUT_POS = IMG_W - WIN + 1;
  localparam int LB_ROWS = WIN - 1;
  localparam int IMGIN_W = WIN * WIN * PIX_W;

  typedef logic [PIX_W-1:0] pix_t;

  function automatic int idx(input int i, input int j);
    return i * WIN + j;
  endfunction

endpackage

// File: rtl/mnist_line_buffer.sv
// Circular store of the last four image rows.
// Each pixel position has one write port and one 4-byte column read port.
module mnist_line_buffer
  import cnn_pkg::*;
(
  input  logic                     CLK,
  input  logic                     we_i,
  input  logic [1:0]               slot_i,
  input  logic [4:0]               col_i,
  input  pix_t                     wdata_i,
  output logic [LB_ROWS*PIX_W-1:0] rcol_o
);

  pix_t mem_q [LB_ROWS][IMG_W];

  always_ff @(posedge CLK) begin
    if (we_i) mem_q[slot_i][col_i] <= wdata_i;
  end

  // Row r lives in slot r%4. Slot r%4 therefore still holds row r-4 before this write,
  // and byte k of the read is row r-4+k.
  always_comb begin
    rcol_o = '0;
    for (int k = 0; k < LB_ROWS; k++) begin
      rcol_o[k*PIX_W +: PIX_W] = mem_q[2'(slot_i + 2'(k))][col_i];
    end
  end

endmodule

// File: rtl/mnist_window_gen.sv
// Turns a raster 28x28 pixel stream into 5x5 IMGIN windows with X/Y coordinates.
// It also issues the per-image START pulse for simpleCNN.
module mnist_window_gen
  import cnn_pkg::*;
(
  input  logic               CLK,
  input  logic               nRST,
  input  logic               PIX_VALID,
  input  logic               PIX_SOF,
  input  logic [PIX_W-1:0]   PIX_DATA,
  output logic               PIX_READY,
  output logic               START,
  output logic               WIN_VALID,
  input  logic               WIN_READY,
  output logic [IMGIN_W-1:0] IMGIN,
  output logic [4:0]         X,
  output logic [4:0]         Y,
  output logic               WIN_LAST
);

  logic                     rdy_q, start_q, valid_q, last_q;
  logic [4:0]               row_q, row_d, col_q, col_d;
  logic [4:0]               r_cur, c_cur, x_q, y_q;
  logic [IMGIN_W-1:0]       win_q, win_d;
  logic [LB_ROWS*PIX_W-1:0] rcol;
  logic                     accept, emit;

  assign PIX_READY = rdy_q & (~valid_q | WIN_READY);
  assign accept    = PIX_VALID & PIX_READY;

  // SOF forces the accepted pixel to position (0,0).
  assign r_cur = PIX_SOF ? 5'd0 : row_q;
  assign c_cur = PIX_SOF ? 5'd0 : col_q;
  assign emit  = accept && (r_cur >= 5'(WIN-1)) && (c_cur >= 5'(WIN-1));

  always_comb begin
    row_d = r_cur;
    col_d = c_cur + 5'd1;
    if (c_cur == 5'(IMG_W-1)) begin
      col_d = 5'd0;
      row_d = (r_cur == 5'(IMG_W-1)) ? 5'd0 : r_cur + 5'd1;
    end
  end

  mnist_line_buffer u_lb (
    .CLK     (CLK),
    .we_i    (accept),
    .slot_i  (r_cur[1:0]),
    .col_i   (c_cur),
    .wdata_i (PIX_DATA),
    .rcol_o  (rcol)
  );

  // Shift the window left by one column and insert the new column at the right edge.
  always_comb begin
    win_d = win_q;
    for (int i = 0; i < WIN; i++) begin
      for (int j = 0; j < WIN; j++) begin
        if (j < WIN-1)
          win_d[idx(i, j)*PIX_W +: PIX_W] = win_q[idx(i, j+1)*PIX_W +: PIX_W];
        else if (i < WIN-1)
          win_d[idx(i, j)*PIX_W +: PIX_W] = rcol[i*PIX_W +: PIX_W];
        else
          win_d[idx(i, j)*PIX_W +: PIX_W] = PIX_DATA;
      end
    end
  end

  // The window register doubles as the IMGIN output register.
  // It only advances on an accepted pixel, and pixels cannot be accepted while a window is stalled.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rdy_q   <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      win_q   <= '0;
    end else begin
      rdy_q   <= 1'b1;
      start_q <= accept && (r_cur == 5'd0) && (c_cur == 5'd0);
      if (accept) begin
        row_q <= row_d;
        col_q <= col_d;
        win_q <= win_d;
      end
      if (emit) begin
        valid_q <= 1'b1;
        x_q     <= r_cur - 5'(WIN-1);
        y_q     <= c_cur - 5'(WIN-1);
        last_q  <= (r_cur == 5'(IMG_W-1)) && (c_cur == 5'(IMG_W-1));
      end else if (WIN_READY) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign START     = start_q;
  assign WIN_VALID = valid_q;
  assign IMGIN     = win_q;
  assign X         = x_q;
  assign Y         = y_q;
  assign WIN_LAST  = last_q;

endmodule

// File: tb/tb_mnist_window_gen.sv
// Directed bench for mnist_window_gen using ramp images.
// It checks window tables, backpressure, back-to-back images, SOF resync and mid-frame reset.
module tb_mnist_window_gen;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         PIX_VALID = 1'b0;
  logic         PIX_SOF = 1'b0;
  logic [7:0]   PIX_DATA = 8'd0;
  logic         WIN_READY = 1'b1;
  logic         PIX_READY, START, WIN_VALID, WIN_LAST;
  logic [199:0] IMGIN;
  logic [4:0]   X, Y;

  always #5 CLK = ~CLK;

  mnist_window_gen dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .PIX_VALID (PIX_VALID),
    .PIX_SOF   (PIX_SOF),
    .PIX_DATA  (PIX_DATA),
    .PIX_READY (PIX_READY),
    .START     (START),
    .WIN_VALID (WIN_VALID),
    .WIN_READY (WIN_READY),
    .IMGIN     (IMGIN),
    .X         (X),
    .Y         (Y),
    .WIN_LAST  (WIN_LAST)
  );

  typedef struct {
    int n; int x; int y; int last; int b0; int b1; int b5; int b24;
  } wv_t;

  int n_cmp = 0;
  int n_fail = 0;
  int start_cnt = 0;
  int win_cnt = 0;
  int frame_gen = 0;

  logic [4:0]   cap_x [576];
  logic [4:0]   cap_y [576];
  logic         cap_last [576];
  logic [199:0] cap_img [576];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] ramp(input int r, input int c);
    return 8'(r * 28 + c);
  endfunction

  // Scoreboard: every handshaken window must be the next one in scan order with ramp data.
  task automatic monitor();
    int ex, ey, gidx, seen, bad;
    ex = 0; ey = 0; gidx = 0; seen = 0;
    forever begin
      @(negedge CLK);
      if (seen != frame_gen) begin
        seen = frame_gen; ex = 0; ey = 0; gidx = 0;
      end
      if (nRST && START) start_cnt++;
      if (nRST && WIN_VALID && WIN_READY) begin
        check("win_pos", 32'({X, Y, WIN_LAST}),
              32'({5'(ex), 5'(ey), (ex == 23 && ey == 23)}));
        bad = 0;
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            if (IMGIN[(i*5+j)*8 +: 8] !== ramp(ex + i, ey + j)) bad++;
        check("win_data", 32'(bad), 32'd0);
        if (frame_gen == 0 && gidx < 576) begin
          cap_x[gidx] = X; cap_y[gidx] = Y; cap_last[gidx] = WIN_LAST; cap_img[gidx] = IMGIN;
        end
        gidx++;
        win_cnt++;
        if (ey == 23) begin
          ey = 0;
          ex = (ex == 23) ? 0 : ex + 1;
        end else begin
          ey++;
        end
      end
    end
  endtask

  task automatic send_range(input int from, input int to, input bit sof);
    bit ok;
    for (int p = from; p <= to; p++) begin
      ok = 1'b0;
      PIX_VALID = 1'b1;
      PIX_DATA  = 8'(p);
      PIX_SOF   = sof && (p == from);
      for (int t = 0; t < 200 && !ok; t++) begin
        @(negedge CLK);
        ok = PIX_READY;
        @(posedge CLK);
        #1;
      end
      if (!ok) begin
        check("pix_accept_timeout", 32'(ok), 32'd1);
        PIX_VALID = 1'b0;
        PIX_SOF   = 1'b0;
        return;
      end
    end
    PIX_VALID = 1'b0;
    PIX_SOF   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    wv_t tbl [5];
    int s0, w0;
    bit hold_ok, stall_rdy_ok;
    logic [199:0] img_s;
    logic [4:0] x_s, y_s;

    tbl[0] = '{n:0,   x:0,  y:0,  last:0, b0:8'h00, b1:8'h01, b5:8'h1C, b24:8'h74};
    tbl[1] = '{n:1,   x:0,  y:1,  last:0, b0:8'h01, b1:8'h02, b5:8'h1D, b24:8'h75};
    tbl[2] = '{n:24,  x:1,  y:0,  last:0, b0:8'h1C, b1:8'h1D, b5:8'h38, b24:8'h90};
    tbl[3] = '{n:300, x:12, y:12, last:0, b0:8'h5C, b1:8'h5D, b5:8'h78, b24:8'hD0};
    tbl[4] = '{n:575, x:23, y:23, last:1, b0:8'h9B, b1:8'h9C, b5:8'hB7, b24:8'h0F};

    fork
      monitor();
    join_none

    repeat (2) @(negedge CLK);
    check("rst_pix_ready", 32'(PIX_READY), 32'd0);
    check("rst_start",     32'(START),     32'd0);
    check("rst_win_valid", 32'(WIN_VALID), 32'd0);
    check("rst_win_last",  32'(WIN_LAST),  32'd0);
    check("rst_xy",        32'({X, Y}),    32'd0);
    check("rst_imgin",     32'(|IMGIN),    32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Image A: latency and window table
    s0 = start_cnt; w0 = win_cnt;
    send_range(0, 115, 0);
    check("lat_before_116", 32'(WIN_VALID), 32'd0);
    send_range(116, 116, 0);
    check("lat_valid_116", 32'(WIN_VALID), 32'd1);
    check("lat_xy_116",    32'({X, Y}),    32'd0);
    send_range(117, 783, 0);
    idle(3);
    check("a_windows", 32'(win_cnt - w0),   32'd576);
    check("a_starts",  32'(start_cnt - s0), 32'd1);
    for (int k = 0; k < 5; k++) begin
      int n;
      n = tbl[k].n;
      check($sformatf("tbl%0d_x", n),    32'(cap_x[n]),              32'(tbl[k].x));
      check($sformatf("tbl%0d_y", n),    32'(cap_y[n]),              32'(tbl[k].y));
      check($sformatf("tbl%0d_last", n), 32'(cap_last[n]),           32'(tbl[k].last));
      check($sformatf("tbl%0d_b0", n),   32'(cap_img[n][0*8 +: 8]),  32'(tbl[k].b0));
      check($sformatf("tbl%0d_b1", n),   32'(cap_img[n][1*8 +: 8]),  32'(tbl[k].b1));
      check($sformatf("tbl%0d_b5", n),   32'(cap_img[n][5*8 +: 8]),  32'(tbl[k].b5));
      check($sformatf("tbl%0d_b24", n),  32'(cap_img[n][24*8 +: 8]), 32'(tbl[k].b24));
    end

    // Image B: stall at window (5,7)
    s0 = start_cnt; w0 = win_cnt;
    send_range(0, 263, 0);
    check("bp_win_valid", 32'(WIN_VALID), 32'd1);
    check("bp_xy",        32'({X, Y}),    32'({5'd5, 5'd7}));
    WIN_READY = 1'b0;
    img_s = IMGIN; x_s = X; y_s = Y;
    hold_ok = 1'b1; stall_rdy_ok = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      if (PIX_READY !== 1'b0) stall_rdy_ok = 1'b0;
      if (IMGIN !== img_s || X !== x_s || Y !== y_s || WIN_VALID !== 1'b1) hold_ok = 1'b0;
    end
    check("bp_pix_ready_low", 32'(stall_rdy_ok), 32'd1);
    check("bp_output_hold",   32'(hold_ok),      32'd1);
    @(posedge CLK); #1;
    WIN_READY = 1'b1;
    send_range(264, 264, 0);
    check("bp_next_xy", 32'({WIN_VALID, X, Y}), 32'({1'b1, 5'd5, 5'd8}));
    send_range(265, 783, 0);
    idle(3);
    check("b_windows", 32'(win_cnt - w0),   32'd576);
    check("b_starts",  32'(start_cnt - s0), 32'd1);

    // Images C and D back to back
    s0 = start_cnt; w0 = win_cnt;
    send_range(0, 783, 0);
    send_range(0, 783, 0);
    idle(3);
    check("cd_windows", 32'(win_cnt - w0),   32'd1152);
    check("cd_starts",  32'(start_cnt - s0), 32'd2);

    // Image E is cut short at pixel 300 by SOF, which begins image F.
    s0 = start_cnt; w0 = win_cnt;
    send_range(0, 299, 0);
    send_range(0, 0, 1);
    check("sof_start", 32'(START), 32'd1);
    frame_gen++;
    send_range(1, 783, 0);
    idle(3);
    check("ef_windows", 32'(win_cnt - w0),   32'd736);
    check("ef_starts",  32'(start_cnt - s0), 32'd2);

    // Image G is interrupted by a reset at pixel 400. Image H follows without SOF.
    send_range(0, 399, 0);
    nRST = 1'b0;
    frame_gen++;
    @(negedge CLK);
    check("mid_rst_win_valid", 32'(WIN_VALID), 32'd0);
    check("mid_rst_start",     32'(START),     32'd0);
    check("mid_rst_pix_ready", 32'(PIX_READY), 32'd0);
    check("mid_rst_imgin",     32'(|IMGIN),    32'd0);
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    s0 = start_cnt; w0 = win_cnt;
    send_range(0, 783, 0);
    idle(3);
    check("h_windows", 32'(win_cnt - w0),   32'd576);
    check("h_starts",  32'(start_cnt - s0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
